// File: rtl/sysarr_pkg.sv
// Shared types and constants for the FP16 systolic mesh edge feeder.
package sysarr_pkg;

  localparam int W = 16;

  localparam logic [W-1:0] FP16_ZERO = 16'h0000;
  localparam logic [W-1:0] FP16_ONE  = 16'h3C00;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DONE
  } state_e;

endpackage

// File: rtl/sysarr_feeder_if.sv
// Operand-loader / control / mesh-edge bundle of the systolic feeder.
interface sysarr_feeder_if
  import sysarr_pkg::*;
#(
  parameter int LANES = 5
) ();

  logic               in_valid;
  logic               in_ready;
  logic               in_sel;
  logic [3:0]         in_idx;
  logic [W-1:0]       in_data;
  logic               in_err;
  logic               start;
  logic               abort;
  logic               busy;
  logic               feed_valid;
  logic               done;
  logic [LANES*W-1:0] a_out;
  logic [LANES*W-1:0] b_out;

  modport master (
    output in_valid, in_sel, in_idx, in_data, start, abort,
    input  in_ready, in_err, busy, feed_valid, done, a_out, b_out
  );

  modport slave (
    input  in_valid, in_sel, in_idx, in_data, start, abort,
    output in_ready, in_err, busy, feed_valid, done, a_out, b_out
  );

endinterface

// File: rtl/sysarr_feed_bank.sv
// A/B operand register file with per-lane diagonal skew read for step k.
module sysarr_feed_bank
  import sysarr_pkg::*;
#(
  parameter int DIM   = 3,
  parameter int LANES = 5,
  parameter int KW    = 3
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic               sel_i,
  input  logic [3:0]         idx_i,
  input  logic [W-1:0]       data_i,
  input  logic [KW-1:0]      k_i,
  output logic [LANES*W-1:0] a_lanes_o,
  output logic [LANES*W-1:0] b_lanes_o
);

  localparam int N = DIM * DIM;

  logic [W-1:0] mem_a_q [N];
  logic [W-1:0] mem_b_q [N];
  logic [W-1:0] eff_a   [N];
  logic [W-1:0] eff_b   [N];

  // NOTE: the banks are reset because a feed straight after reset must stream +0.0, not X.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < N; e++) begin
        mem_a_q[e] <= FP16_ZERO;
        mem_b_q[e] <= FP16_ZERO;
      end
    end else if (we_i) begin
      for (int e = 0; e < N; e++) begin
        if (idx_i == 4'(e)) begin
          if (sel_i) mem_b_q[e] <= data_i;
          else       mem_a_q[e] <= data_i;
        end
      end
    end
  end

  // A write landing on the same edge as the first step is forwarded so the feed sees it.
  always_comb begin
    for (int e = 0; e < N; e++) begin
      eff_a[e] = (we_i && !sel_i && idx_i == 4'(e)) ? data_i : mem_a_q[e];
      eff_b[e] = (we_i &&  sel_i && idx_i == 4'(e)) ? data_i : mem_b_q[e];
    end
  end

  // NOTE: defaulting every output first keeps this block free of inferred latches.
  always_comb begin
    a_lanes_o = '0;
    b_lanes_o = '0;
    for (int l = 0; l < DIM; l++) begin
      for (int c = 0; c < DIM; c++) begin
        if (k_i == KW'(l + c)) begin
          a_lanes_o[l*W +: W] = eff_a[l*DIM + c];
          b_lanes_o[l*W +: W] = eff_b[c*DIM + l];
        end
      end
    end
  end

endmodule

// File: rtl/sysarr_feeder.sv
// Edge feeder for the FP16 systolic mesh: buffers A/B, then streams skewed lanes and flushes.
module sysarr_feeder
  import sysarr_pkg::*;
#(
  parameter int DIM       = 3,
  parameter int LANES     = 5,
  parameter int FLUSH_CYC = 7
) (
  input  logic           clock,
  input  logic           rst_n,
  sysarr_feeder_if.slave bus
);

  localparam int N      = DIM * DIM;
  localparam int KW     = $clog2(2 * DIM);
  localparam int FW     = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int F_LAST = (FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0;
  localparam logic [KW-1:0] K_LAST = KW'(2 * DIM - 2);

  state_e             state_q;
  logic [KW-1:0]      k_q;
  logic [KW-1:0]      k_rd;
  logic [FW-1:0]      f_q;
  logic [LANES*W-1:0] a_q, b_q;
  logic [LANES*W-1:0] a_nxt, b_nxt;
  logic               fv_q, done_q, err_q;
  logic               idle, wr_accept, idx_ok;

  assign idle      = (state_q == IDLE);
  assign wr_accept = bus.in_valid && idle;
  assign idx_ok    = (bus.in_idx < 4'(N));

  // The bank is read at the step being loaded into the output registers this edge.
  assign k_rd = (state_q == FEED) ? k_q + KW'(1) : '0;

  sysarr_feed_bank #(
    .DIM   (DIM),
    .LANES (LANES),
    .KW    (KW)
  ) u_bank (
    .clock     (clock),
    .rst_n     (rst_n),
    .we_i      (wr_accept && idx_ok),
    .sel_i     (bus.in_sel),
    .idx_i     (bus.in_idx),
    .data_i    (bus.in_data),
    .k_i       (k_rd),
    .a_lanes_o (a_nxt),
    .b_lanes_o (b_nxt)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      f_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q  <= wr_accept && !idx_ok;
      fv_q   <= 1'b0;
      done_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= FEED;
            k_q     <= '0;
            fv_q    <= 1'b1;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
          end
        end
        FEED: begin
          if (bus.abort) begin
            state_q <= IDLE;
            k_q     <= '0;
          end else if (k_q == K_LAST) begin
            k_q     <= '0;
            f_q     <= '0;
            state_q <= (FLUSH_CYC == 0) ? DONE : FLUSH;
            done_q  <= (FLUSH_CYC == 0);
          end else begin
            k_q  <= k_q + KW'(1);
            fv_q <= 1'b1;
            a_q  <= a_nxt;
            b_q  <= b_nxt;
          end
        end
        FLUSH: begin
          if (bus.abort) begin
            state_q <= IDLE;
            f_q     <= '0;
          end else if (f_q == FW'(F_LAST)) begin
            state_q <= DONE;
            f_q     <= '0;
            done_q  <= 1'b1;
          end else begin
            f_q <= f_q + FW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = idle;
  assign bus.busy       = !idle;
  assign bus.in_err     = err_q;
  assign bus.feed_valid = fv_q;
  assign bus.done       = done_q;
  assign bus.a_out      = a_q;
  assign bus.b_out      = b_q;

endmodule

// File: tb/tb_sysarr_feeder.sv
// Directed + randomized bench for sysarr_feeder against a matrix-level stream model.
module tb_sysarr_feeder;
  import sysarr_pkg::*;

  localparam int DIM   = 3;
  localparam int LANES = 5;
  localparam int FL    = 7;
  localparam int LW    = LANES * W;
  localparam int NFEED = 2 * DIM - 1;
  localparam int TDONE = NFEED + FL + 1;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  sysarr_feeder_if #(.LANES(LANES)) if1 ();
  sysarr_feeder_if #(.LANES(LANES)) if2 ();

  sysarr_feeder #(.DIM(DIM), .LANES(LANES), .FLUSH_CYC(FL)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (if1)
  );

  sysarr_feeder #(.DIM(DIM), .LANES(LANES), .FLUSH_CYC(0)) dut0 (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (if2)
  );

  assign if2.in_valid = if1.in_valid;
  assign if2.in_sel   = if1.in_sel;
  assign if2.in_idx   = if1.in_idx;
  assign if2.in_data  = if1.in_data;
  assign if2.start    = if1.start;
  assign if2.abort    = if1.abort;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] ma [DIM][DIM];
  logic [W-1:0] mb [DIM][DIM];

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] exp_a(input int k);
    logic [LW-1:0] r = '0;
    for (int i = 0; i < DIM; i++)
      if (k - i >= 0 && k - i < DIM) r[i*W +: W] = ma[i][k-i];
    return r;
  endfunction

  function automatic logic [LW-1:0] exp_b(input int k);
    logic [LW-1:0] r = '0;
    for (int j = 0; j < DIM; j++)
      if (k - j >= 0 && k - j < DIM) r[j*W +: W] = mb[k-j][j];
    return r;
  endfunction

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_model();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        ma[r][c] = FP16_ZERO;
        mb[r][c] = FP16_ZERO;
      end
  endtask

  task automatic wr(input bit sel, input int idx, input logic [W-1:0] d);
    if1.in_valid = 1'b1;
    if1.in_sel   = sel;
    if1.in_idx   = 4'(idx);
    if1.in_data  = d;
    cycle();
    if1.in_valid = 1'b0;
    chk($sformatf("in_err idx=%0d", idx), LW'(if1.in_err), LW'(idx >= DIM * DIM));
    if (idx < DIM * DIM) begin
      if (sel) mb[idx / DIM][idx % DIM] = d;
      else     ma[idx / DIM][idx % DIM] = d;
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, " a_out"},      if1.a_out, '0);
    chk({tag, " b_out"},      if1.b_out, '0);
    chk({tag, " feed_valid"}, LW'(if1.feed_valid), '0);
    chk({tag, " done"},       LW'(if1.done), '0);
    chk({tag, " busy"},       LW'(if1.busy), '0);
    chk({tag, " in_ready"},   LW'(if1.in_ready), LW'(1));
  endtask

  // One full run from start; poke_c injects start+write at that busy cycle.
  task automatic run_feed(input string tag, input bit chk0, input int poke_c,
                          input bit wr_start, input logic [W-1:0] wv);
    if1.start = 1'b1;
    if (wr_start) begin
      if1.in_valid = 1'b1;
      if1.in_sel   = 1'b0;
      if1.in_idx   = 4'd0;
      if1.in_data  = wv;
      ma[0][0]     = wv;
    end
    cycle();
    if1.start    = 1'b0;
    if1.in_valid = 1'b0;
    for (int c = 1; c <= TDONE + 1; c++) begin
      automatic bit in_feed = (c <= NFEED);
      automatic bit busy_e  = (c <= TDONE);
      chk($sformatf("%s a_out c%0d", tag, c), if1.a_out, in_feed ? exp_a(c - 1) : '0);
      chk($sformatf("%s b_out c%0d", tag, c), if1.b_out, in_feed ? exp_b(c - 1) : '0);
      chk($sformatf("%s fv c%0d", tag, c),    LW'(if1.feed_valid), LW'(in_feed));
      chk($sformatf("%s done c%0d", tag, c),  LW'(if1.done), LW'(c == TDONE));
      chk($sformatf("%s busy c%0d", tag, c),  LW'(if1.busy), LW'(busy_e));
      chk($sformatf("%s rdy c%0d", tag, c),   LW'(if1.in_ready), LW'(!busy_e));
      chk($sformatf("%s err c%0d", tag, c),   LW'(if1.in_err), '0);
      if (chk0) begin
        chk($sformatf("%s f0 fv c%0d", tag, c),   LW'(if2.feed_valid), LW'(in_feed));
        chk($sformatf("%s f0 done c%0d", tag, c), LW'(if2.done), LW'(c == NFEED + 1));
      end
      if1.start    = (c == poke_c);
      if1.in_valid = (c == poke_c);
      if1.in_sel   = 1'b0;
      if1.in_idx   = 4'd0;
      if1.in_data  = 16'hDEAD;
      cycle();
    end
    if1.start    = 1'b0;
    if1.in_valid = 1'b0;
  endtask

  initial begin
    if1.in_valid = 1'b0;
    if1.in_sel   = 1'b0;
    if1.in_idx   = 4'd0;
    if1.in_data  = '0;
    if1.start    = 1'b0;
    if1.abort    = 1'b0;
    clear_model();

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check_idle_zero("reset");
    chk("reset in_err", LW'(if1.in_err), '0);
    rst_n = 1'b1;
    @(negedge clock);
    chk("post-reset in_ready", LW'(if1.in_ready), LW'(1));

    // Identity A, B all 2.0; also checks the FLUSH_CYC=0 build
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        wr(1'b0, r * DIM + c, (r == c) ? FP16_ONE : FP16_ZERO);
        wr(1'b1, r * DIM + c, 16'h4000);
      end
    run_feed("ident", 1'b1, 0, 1'b0, '0);

    // Out-of-range writes are flagged and discarded
    wr(1'b0, 9, 16'h1234);
    wr(1'b1, 15, 16'h1234);
    run_feed("badidx", 1'b0, 0, 1'b0, '0);

    // Random operands, NaN/denormal patterns included, write on the start cycle
    for (int e = 0; e < DIM * DIM; e++) begin
      wr(1'b0, e, 16'($urandom));
      wr(1'b1, e, 16'($urandom));
    end
    wr(1'b0, 4, 16'h7E01);
    wr(1'b1, 8, 16'h0001);
    run_feed("rand", 1'b0, 0, 1'b1, 16'($urandom));

    // Abort at FLUSH f=3
    if1.start = 1'b1;
    cycle();
    if1.start = 1'b0;
    repeat (NFEED + 3) cycle();
    chk("abort pre fv", LW'(if1.feed_valid), '0);
    chk("abort pre busy", LW'(if1.busy), LW'(1));
    if1.abort = 1'b1;
    cycle();
    if1.abort = 1'b0;
    check_idle_zero("abort");
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("abort no done %0d", i), LW'(if1.done), '0);
      cycle();
    end

    // Start/write during FEED ignored; back-to-back runs stream identically
    run_feed("busy-poke", 1'b0, 2, 1'b0, '0);
    run_feed("b2b", 1'b0, 0, 1'b0, '0);

    // Reset mid-FEED at step 2
    if1.start = 1'b1;
    cycle();
    if1.start = 1'b0;
    cycle();
    cycle();
    chk("pre-rst step2 a_out", if1.a_out, exp_a(2));
    rst_n = 1'b0;
    #1;
    check_idle_zero("async rst");
    chk("async rst in_err", LW'(if1.in_err), '0);
    clear_model();
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    run_feed("banks cleared", 1'b0, 0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
